// File: rtl/memoria_ctrl_if.sv
// -----------------------------------------------------------------------------
// memoria_ctrl_if
//   Request bundle for the memoria write-port controller: two requesters
//   (A and B), each with its own valid/sel/data and a ready returned by the
//   controller.
//
//   Handshake: a requester raises x_valid together with a stable x_sel/x_data
//   and holds all three until x_ready is seen high. A write is transferred in
//   exactly the cycle where x_valid && x_ready, sampled on the rising clock
//   edge. x_ready may rise and fall combinationally within a cycle and never
//   depends on anything except the controller state and the current inputs.
//
//   Parameters
//     N        data width of a_data / b_data
//
//   Modports
//     master   requester side: drives valid/sel/data, receives ready
//     slave    controller side: receives valid/sel/data, drives ready
// -----------------------------------------------------------------------------
interface memoria_ctrl_if #(
    parameter int N = 16
) ();
    logic         a_valid;
    logic [3:0]   a_sel;
    logic [N-1:0] a_data;
    logic         a_ready;

    logic         b_valid;
    logic [3:0]   b_sel;
    logic [N-1:0] b_data;
    logic         b_ready;

    modport master (
        output a_valid, a_sel, a_data,
        input  a_ready,
        output b_valid, b_sel, b_data,
        input  b_ready
    );

    modport slave (
        input  a_valid, a_sel, a_data,
        output a_ready,
        input  b_valid, b_sel, b_data,
        output b_ready
    );
endinterface

// File: rtl/memoria_ctrl.sv
// -----------------------------------------------------------------------------
// memoria_ctrl
//   Write-port controller for the 16-entry memoria register bank.
//   - Arbitrates requesters A and B with round-robin priority on contention.
//   - Runs a bulk CLEAR that writes CLR_VAL into entries 0..15, one per cycle.
//   - Drives the bank's w / select_register / s from flops.
//
//   Optional feature (macro MEMCTRL_LOCK_EN):
//     defined   : a write or CLEAR step whose target has lock_mask[entry]=1 is
//                 still accepted / still takes its cycle, but w stays 0 and
//                 err_lock pulses for one cycle instead.
//     undefined : lock_mask is ignored and err_lock is constant 0.
//
//   Parameters
//     N         data width (bank word width)
//     CLR_VAL   value written to every entry during CLEAR
//
//   Ports
//     clk              rising-edge clock
//     rst              asynchronous, active-low reset
//     req              memoria_ctrl_if.slave: a_/b_ valid, sel, data, ready
//     clr_start        request a CLEAR (level-sampled only in IDLE)
//     clr_busy         high for each cycle a CLEAR step is on the outputs
//     lock_mask        per-entry write lock (MEMCTRL_LOCK_EN only)
//     err_lock         one-cycle pulse when a write/CLEAR step was blocked
//     w                bank write enable
//     select_register  bank entry index
//     s                bank write data
//     dbg_state        current FSM state (0 = IDLE, 1 = CLEAR)
//
//   Timing: a handshake in cycle T shows up on w/select_register/s in T+1.
//   The CLEAR state lasts exactly 16 cycles; in each of them the outputs show
//   the entry equal to the clear counter. a_ready/b_ready are 0 throughout.
// -----------------------------------------------------------------------------
module memoria_ctrl #(
    parameter int           N       = 16,
    parameter logic [N-1:0] CLR_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    memoria_ctrl_if.slave        req,
    input  logic                 clr_start,
    output logic                 clr_busy,
    input  logic [15:0]          lock_mask,
    output logic                 err_lock,
    output logic                 w,
    output logic [3:0]           select_register,
    output logic [N-1:0]         s,
    output logic                 dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // rr_ptr: 0 = A has priority on the next contested cycle, 1 = B.
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    state_e       state, state_nxt;
    logic         rr_ptr, rr_nxt;
    logic [3:0]   cnt, cnt_nxt;

    logic         grant_a, grant_b;
    logic         w_nxt;
    logic [3:0]   sel_nxt;
    logic [N-1:0] s_nxt;
    logic         err_nxt;
    logic         busy_nxt;
    logic         blocked;

`ifdef MEMCTRL_LOCK_EN
    // The lock is checked against the entry that is about to be driven, so a
    // blocked step still consumes its cycle and the CLEAR length is unchanged.
    assign blocked = lock_mask[sel_nxt];
`else
    logic unused_lock;
    assign unused_lock = ^lock_mask;
    assign blocked     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state, grant and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        cnt_nxt   = cnt;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        w_nxt     = 1'b0;
        sel_nxt   = select_register;
        s_nxt     = s;
        busy_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    // CLEAR wins over any pending request; entry 0 is driven
                    // in the first CLEAR cycle.
                    state_nxt = CLEAR;
                    cnt_nxt   = 4'd0;
                    busy_nxt  = 1'b1;
                    w_nxt     = 1'b1;
                    sel_nxt   = 4'd0;
                    s_nxt     = CLR_VAL;
                end else begin
                    if (req.a_valid && req.b_valid) begin
                        // Contested: serve the pointer's side, then hand
                        // priority to the other side.
                        grant_a = (rr_ptr == RR_A);
                        grant_b = (rr_ptr == RR_B);
                        rr_nxt  = ~rr_ptr;
                    end else begin
                        grant_a = req.a_valid;
                        grant_b = req.b_valid;
                    end

                    if (grant_a) begin
                        w_nxt   = 1'b1;
                        sel_nxt = req.a_sel;
                        s_nxt   = req.a_data;
                    end else if (grant_b) begin
                        w_nxt   = 1'b1;
                        sel_nxt = req.b_sel;
                        s_nxt   = req.b_data;
                    end
                end
            end

            CLEAR: begin
                if (cnt == 4'd15) begin
                    // Entry 15 is on the outputs now; leave CLEAR on this edge.
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt  = cnt + 4'd1;
                    busy_nxt = 1'b1;
                    w_nxt    = 1'b1;
                    sel_nxt  = cnt + 4'd1;
                    s_nxt    = CLR_VAL;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        err_nxt = w_nxt & blocked;
        if (blocked) begin
            w_nxt = 1'b0;
        end
    end

    // Ready is combinational; forced low while reset is held so no
    // handshake can be seen by a requester during reset.
    assign req.a_ready = grant_a & rst;
    assign req.b_ready = grant_b & rst;

    assign dbg_state = (state == CLEAR);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= RR_A;
            cnt    <= 4'd0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered bank-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w               <= 1'b0;
            select_register <= 4'd0;
            s               <= '0;
            clr_busy        <= 1'b0;
            err_lock        <= 1'b0;
        end else begin
            w               <= w_nxt;
            select_register <= sel_nxt;
            s               <= s_nxt;
            clr_busy        <= busy_nxt;
            err_lock        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_memoria_ctrl.sv
// -----------------------------------------------------------------------------
// tb_memoria_ctrl
//   Bench for memoria_ctrl. A reference model tracks the expected bank-side
//   outputs cycle by cycle: a CLEAR is modelled as a queue of the 16 entries
//   it will write, a request write as a single expected transfer, and the
//   round-robin as a "whose turn" flag that flips on contention.
//   Build with +define+MEMCTRL_LOCK_EN to check the lock feature.
// -----------------------------------------------------------------------------
module tb_memoria_ctrl;

    localparam int           N       = 16;
    localparam logic [N-1:0] CLR_VAL = '0;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        clr_start;
    logic        clr_busy;
    logic [15:0] lock_mask;
    logic        err_lock;
    logic        w;
    logic [3:0]  select_register;
    logic [N-1:0] s;
    logic        dbg_state;

    memoria_ctrl_if #(.N(N)) bus ();

    memoria_ctrl #(.N(N), .CLR_VAL(CLR_VAL)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (bus),
        .clr_start       (clr_start),
        .clr_busy        (clr_busy),
        .lock_mask       (lock_mask),
        .err_lock        (err_lock),
        .w               (w),
        .select_register (select_register),
        .s               (s),
        .dbg_state       (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int tests = 0;
    int fails = 0;

    logic [3:0] exp_q[$];     // remaining CLEAR entries still to appear
    logic       m_turn_b;     // contested grant goes to B when set
    logic       m_busy;
    logic       m_w;
    logic [3:0] m_sel;
    logic [N-1:0] m_s;
    logic       m_err;
    logic       m_ga, m_gb;   // grants observed in the most recent step

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic locked(input logic [3:0] e);
`ifdef MEMCTRL_LOCK_EN
        return lock_mask[e];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_turn_b = 1'b0;
        m_busy   = 1'b0;
        m_w      = 1'b0;
        m_sel    = 4'd0;
        m_s      = '0;
        m_err    = 1'b0;
        m_ga     = 1'b0;
        m_gb     = 1'b0;
    endtask

    // One clock cycle. Called at a falling edge with inputs already driven.
    task automatic step();
        logic       ga, gb;
        logic [3:0] e;
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (rst && !m_busy && !clr_start) begin
            if (bus.a_valid && bus.b_valid) begin
                ga = !m_turn_b;
                gb = m_turn_b;
            end else begin
                ga = bus.a_valid;
                gb = bus.b_valid;
            end
        end
        chk("a_ready", 32'(bus.a_ready), 32'(ga));
        chk("b_ready", 32'(bus.b_ready), 32'(gb));

        @(posedge clk);
        if (exp_q.size() != 0) begin
            e      = exp_q.pop_front();
            m_busy = 1'b1;
            m_sel  = e;
            m_s    = CLR_VAL;
            m_err  = locked(e);
            m_w    = !m_err;
        end else if (!m_busy && clr_start) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
            e      = exp_q.pop_front();
            m_busy = 1'b1;
            m_sel  = e;
            m_s    = CLR_VAL;
            m_err  = locked(e);
            m_w    = !m_err;
        end else if (ga || gb) begin
            m_busy = 1'b0;
            m_sel  = ga ? bus.a_sel : bus.b_sel;
            m_s    = ga ? bus.a_data : bus.b_data;
            m_err  = locked(m_sel);
            m_w    = !m_err;
            if (bus.a_valid && bus.b_valid) m_turn_b = !m_turn_b;
        end else begin
            m_busy = 1'b0;
            m_w    = 1'b0;
            m_err  = 1'b0;
        end
        m_ga = ga;
        m_gb = gb;

        #1;
        chk("w", 32'(w), 32'(m_w));
        chk("err_lock", 32'(err_lock), 32'(m_err));
        chk("clr_busy", 32'(clr_busy), 32'(m_busy));
        chk("state", 32'(dbg_state), 32'(m_busy));
        if (m_w || m_err) begin
            chk("select_register", 32'(select_register), 32'(m_sel));
            chk("s", 32'(s), 32'(m_s));
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w"}, 32'(w), 32'd0);
        chk({tag, "_sel"}, 32'(select_register), 32'd0);
        chk({tag, "_s"}, 32'(s), 32'd0);
        chk({tag, "_busy"}, 32'(clr_busy), 32'd0);
        chk({tag, "_err"}, 32'(err_lock), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
        chk({tag, "_a_ready"}, 32'(bus.a_ready), 32'd0);
        chk({tag, "_b_ready"}, 32'(bus.b_ready), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    int wc, ec;
    logic exp_lock_w;

    initial begin
        rst         = 1'b1;
        clr_start   = 1'b0;
        lock_mask   = 16'h0000;
        bus.a_valid = 1'b0; bus.a_sel = 4'd0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_sel = 4'd0; bus.b_data = '0;
        model_reset();

        // Reset state, with both requesters asking so ready=0 is meaningful
        #3 rst = 1'b0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // 1: single write from A
        bus.a_valid = 1'b1; bus.a_sel = 4'd3; bus.a_data = 16'h1234;
        step();
        chk("t1_w", 32'(w), 32'd1);
        chk("t1_sel", 32'(select_register), 32'd3);
        chk("t1_s", 32'(s), 32'h1234);
        bus.a_valid = 1'b0;
        step();

        // 2: contention, alternating grants A,B,A,B
        bus.a_valid = 1'b1; bus.a_sel = 4'd1; bus.a_data = 16'hAAAA;
        bus.b_valid = 1'b1; bus.b_sel = 4'd2; bus.b_data = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_w", 32'(w), 32'd1);
            chk("t2_sel", 32'(select_register), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        step();

        // 3: CLEAR with A pending; A served right after CLEAR ends
        bus.a_valid = 1'b1; bus.a_sel = 4'd5; bus.a_data = 16'h5555;
        clr_start = 1'b1;
        wc = 0;
        step();
        clr_start = 1'b0;
        if (w === 1'b1 && select_register === 4'd0) wc++;
        for (int i = 1; i < 16; i++) begin
            step();
            if (w === 1'b1 && select_register === 4'(i)) wc++;
        end
        chk("t3_clear_writes", 32'(wc), 32'd16);
        step();   // last CLEAR cycle: entry 15 on outputs, A still waiting
        chk("t3_busy_done", 32'(clr_busy), 32'd0);
        step();   // A granted in IDLE
        chk("t3_a_w", 32'(w), 32'd1);
        chk("t3_a_sel", 32'(select_register), 32'd5);
        bus.a_valid = 1'b0;
        step();

        // 4: reset during CLEAR step 7
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        bus.a_valid = 1'b1; bus.a_sel = 4'd9;
        #2 rst = 1'b0;
        #1 chk_all_zero("t4_async");
        model_reset();
        @(posedge clk);
        #1 chk_all_zero("t4_held");
        @(negedge clk);
        rst = 1'b1;
        bus.a_valid = 1'b0;
        step();
        chk("t4_no_w", 32'(w), 32'd0);

        // 5/6: lock on entry 0
`ifdef MEMCTRL_LOCK_EN
        exp_lock_w = 1'b0;
`else
        exp_lock_w = 1'b1;
`endif
        lock_mask = 16'h0001;
        bus.b_valid = 1'b1; bus.b_sel = 4'd0; bus.b_data = 16'hBEEF;
        step();
        chk("t5_w", 32'(w), 32'(exp_lock_w));
        chk("t5_err", 32'(err_lock), 32'(!exp_lock_w));
        bus.b_valid = 1'b0;
        step();
        clr_start = 1'b1;
        wc = 0; ec = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            clr_start = 1'b0;
            if (w === 1'b1) wc++;
            if (err_lock === 1'b1) ec++;
        end
        chk("t5_clear_writes", 32'(wc), exp_lock_w ? 32'd16 : 32'd15);
        chk("t5_clear_errs", 32'(ec), exp_lock_w ? 32'd0 : 32'd1);
        lock_mask = 16'h0000;

        // Random traffic against the model
        m_ga = 1'b0;
        m_gb = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.a_valid || m_ga) begin
                bus.a_valid = ($urandom_range(0, 2) != 0);
                bus.a_sel   = 4'($urandom_range(0, 15));
                bus.a_data  = N'($urandom);
            end
            if (!bus.b_valid || m_gb) begin
                bus.b_valid = ($urandom_range(0, 2) != 0);
                bus.b_sel   = 4'($urandom_range(0, 15));
                bus.b_data  = N'($urandom);
            end
            clr_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 63) == 0) lock_mask = 16'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
